// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Collects the 1-cycle rising/falling edge pulses from NCHAN input
//   conditioners. It issues them one at a time as a registered event
//   stream with a valid/ready handshake. Channels are served round-robin.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   posedge_in/negedge_in     per-channel edge pulses (never back-pressured)
//   evt_valid/evt_ready       event handshake
//   evt_chan/evt_rising       presented event: channel index and polarity
//   pending                   channel has at least one un-issued event
//   overflow                  sticky per-channel "edge merged/lost" flag
//   ovf_clear                 synchronous clear of all overflow bits

// Per-channel capture: one pending bit per polarity plus an order bit.
// On a grant (iss) the channel drops its older pending polarity.
module edge_event_chan (
    input  logic clk,
    input  logic reset_n,
    input  logic pos,
    input  logic neg,
    input  logic iss,
    input  logic ovf_clear,
    output logic pend_r,
    output logic pend_f,
    output logic older_rise,
    output logic ovf
);
    logic rise_first;
    logic r_keep, f_keep;

    assign older_rise = (pend_r & pend_f) ? rise_first : pend_r;

    // Bits that survive this edge's grant. A pulse on a bit being issued
    // simply re-sets it and is not counted as a merge.
    assign r_keep = pend_r & ~(iss &  older_rise);
    assign f_keep = pend_f & ~(iss & ~older_rise);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r     <= 1'b0;
            pend_f     <= 1'b0;
            rise_first <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            pend_r <= r_keep | pos;
            pend_f <= f_keep | neg;
            ovf    <= (ovf & ~ovf_clear) | (pos & r_keep) | (neg & f_keep);
            // The order bit tracks whichever polarity is oldest. When only
            // one bit survives, that bit is the older one. When the channel
            // empties, a new arrival sets the order; a rise wins a tie.
            if (r_keep && !f_keep)
                rise_first <= 1'b1;
            else if (f_keep && !r_keep)
                rise_first <= 1'b0;
            else if (!r_keep && !f_keep && (pos || neg))
                rise_first <= pos;
        end
    end
endmodule

module edge_event_arbiter #(
    parameter int NCHAN = 4,
    parameter int CHANW = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCHAN-1:0] posedge_in,
    input  logic [NCHAN-1:0] negedge_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CHANW-1:0] evt_chan,
    output logic             evt_rising,
    output logic [NCHAN-1:0] pending,
    output logic [NCHAN-1:0] overflow,
    input  logic             ovf_clear
);
    typedef enum logic { S_IDLE, S_OFFER } state_t;

    state_t             state, state_nxt;
    logic [NCHAN-1:0]   pend_r, pend_f, older_rise, iss;
    logic [CHANW-1:0]   last, gidx;
    logic               found, load;

    genvar g;
    generate
        for (g = 0; g < NCHAN; g++) begin : g_chan
            edge_event_chan u_chan (
                .clk        (clk),
                .reset_n    (reset_n),
                .pos        (posedge_in[g]),
                .neg        (negedge_in[g]),
                .iss        (iss[g]),
                .ovf_clear  (ovf_clear),
                .pend_r     (pend_r[g]),
                .pend_f     (pend_f[g]),
                .older_rise (older_rise[g]),
                .ovf        (overflow[g])
            );
            assign iss[g] = load && (gidx == CHANW'(g));
        end
    endgenerate

    assign pending = pend_r | pend_f;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int               idx;
        logic [CHANW-1:0] cand;
        found = 1'b0;
        gidx  = '0;
        for (int k = 1; k <= NCHAN; k++) begin
            idx = int'(last) + k;
            if (idx >= NCHAN) idx = idx - NCHAN;
            cand = CHANW'(idx);
            if (!found && pending[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    // A new event is loaded when the output slot is empty or being
    // emptied this edge. Pulses arriving at the same edge are not yet
    // visible in pending, so they cannot be granted yet.
    assign load = found && (state == S_IDLE || evt_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = S_OFFER;
            S_OFFER: if (evt_ready && !load) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign evt_valid = (state == S_OFFER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_chan   <= '0;
            evt_rising <= 1'b0;
            last       <= CHANW'(NCHAN - 1);
        end else if (load) begin
            evt_chan   <= gidx;
            evt_rising <= older_rise[gidx];
            last       <= gidx;
        end
    end
endmodule
